// File: rtl/control_pkg.sv
// Shared op encodings, pointer indices and pointer-update kinds for pointer_memory.
package control;

   typedef enum logic [3:0] {
      NOP      = 4'd0,
      READ     = 4'd1,
      WRITE    = 4'd2,
      ABSOLUTE = 4'd3,
      REL_SUB  = 4'd4,
      REL_ADD  = 4'd5,
      READ_INC = 4'd6,
      PUSH     = 4'd7,
      POP      = 4'd8
   } memory_op_e;

   typedef enum logic [1:0] {
      PU_LOAD = 2'd0,
      PU_ADD  = 2'd1,
      PU_SUB  = 2'd2
   } ptr_upd_e;

   localparam int PTR_MAR = 0;
   localparam int PTR_PC  = 1;
   localparam int PTR_SP  = 2;
   localparam int PTR_IDX = 3;

endpackage

// File: rtl/mem_pointer_file.sv
// Address pointer registers with load/add/sub and sticky wrap flags.
// One update per cycle, visible the cycle after the edge; never stalls.
module mem_pointer_file
   import control::*;
#(
   parameter int PTR_WIDTH  = 8,
   parameter int NUM_PTRS   = 4,
   parameter int PSEL_WIDTH = 2
) (
   input  logic                                 clock_i,
   input  logic                                 reset_i,
   input  logic                                 upd_en_i,
   input  logic [PSEL_WIDTH-1:0]                upd_idx_i,
   input  ptr_upd_e                             upd_kind_i,
   input  logic [PTR_WIDTH-1:0]                 operand_i,
   output logic [NUM_PTRS-1:0][PTR_WIDTH-1:0]   ptrs_o,
   output logic [NUM_PTRS-1:0]                  wrap_o
);

   logic [NUM_PTRS-1:0][PTR_WIDTH-1:0] ptr_q, ptr_d;
   logic [NUM_PTRS-1:0]                wrap_q, wrap_d;
   logic [PTR_WIDTH-1:0]               cur;
   logic [PTR_WIDTH:0]                 sum, diff;

   // Top bit of sum is the carry past all-ones, top bit of diff the borrow below zero.
   always_comb begin
      cur    = ptr_q[upd_idx_i];
      sum    = {1'b0, cur} + {1'b0, operand_i};
      diff   = {1'b0, cur} - {1'b0, operand_i};
      ptr_d  = ptr_q;
      wrap_d = wrap_q;
      if (upd_en_i) begin
         case (upd_kind_i)
            PU_LOAD: begin
               ptr_d[upd_idx_i]  = operand_i;
               wrap_d[upd_idx_i] = 1'b0;
            end
            PU_ADD: begin
               ptr_d[upd_idx_i] = sum[PTR_WIDTH-1:0];
               if (sum[PTR_WIDTH]) wrap_d[upd_idx_i] = 1'b1;
            end
            PU_SUB: begin
               ptr_d[upd_idx_i] = diff[PTR_WIDTH-1:0];
               if (diff[PTR_WIDTH]) wrap_d[upd_idx_i] = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         ptr_q  <= '0;
         wrap_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         wrap_q <= wrap_d;
      end
   end

   assign ptrs_o = ptr_q;
   assign wrap_o = wrap_q;

endmodule

// File: rtl/pointer_memory.sv
// Pointer-addressed cell array: one op per cycle, read data one cycle after request.
// No backpressure; illegal ops behave as NOP and raise op_error the next cycle.
module pointer_memory
   import control::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PTR_WIDTH  = 8,
   parameter int WSEL_WIDTH = 1,
   parameter int NUM_PTRS   = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [DATA_WIDTH-1:0]       in,
   output logic [DATA_WIDTH-1:0]       out,
   output logic                        out_valid,
   input  logic [WSEL_WIDTH-1:0]       word_sel,
   input  logic [$clog2(NUM_PTRS)-1:0] ptr_sel,
   input  memory_op_e                  op,
   output logic [NUM_PTRS-1:0]         wrap_flags,
   output logic                        op_error
);

   localparam int PSEL_W = $clog2(NUM_PTRS);
   localparam int ADDR_W = PTR_WIDTH + WSEL_WIDTH;
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam logic [PSEL_W-1:0] SP_IDX  = PSEL_W'(PTR_SP);
   localparam logic [PSEL_W:0]   NP_WIDE = (PSEL_W + 1)'(NUM_PTRS);

   logic [NUM_PTRS-1:0][PTR_WIDTH-1:0] ptrs;
   logic [DATA_WIDTH-1:0]              mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]              rd_data_q;
   logic                               out_valid_q, op_error_q;
   logic                               illegal, rd_en, wr_en, upd_en;
   ptr_upd_e                           upd_kind;
   logic [PSEL_W-1:0]                  upd_idx;
   logic [PTR_WIDTH-1:0]               operand, acc_ptr;
   logic [ADDR_W-1:0]                  addr;

   always_comb begin
      illegal  = 1'b0;
      rd_en    = 1'b0;
      wr_en    = 1'b0;
      upd_en   = 1'b0;
      upd_kind = PU_LOAD;
      operand  = '0;
      upd_idx  = ptr_sel;
      acc_ptr  = ptrs[ptr_sel];
      case (op)
         NOP:      ;
         READ:     rd_en = 1'b1;
         WRITE:    wr_en = 1'b1;
         ABSOLUTE: begin upd_en = 1'b1; upd_kind = PU_LOAD; operand = PTR_WIDTH'(in); end
         REL_ADD:  begin upd_en = 1'b1; upd_kind = PU_ADD;  operand = PTR_WIDTH'(in); end
         REL_SUB:  begin upd_en = 1'b1; upd_kind = PU_SUB;  operand = PTR_WIDTH'(in); end
         READ_INC: begin rd_en = 1'b1; upd_en = 1'b1; upd_kind = PU_ADD; operand = PTR_WIDTH'(1); end
         // Stack pushes are pre-decrement: the write lands at the new SP.
         PUSH: begin
            upd_idx  = SP_IDX;
            acc_ptr  = ptrs[SP_IDX] - PTR_WIDTH'(1);
            wr_en    = 1'b1;
            upd_en   = 1'b1;
            upd_kind = PU_SUB;
            operand  = PTR_WIDTH'(1);
         end
         POP: begin
            upd_idx  = SP_IDX;
            acc_ptr  = ptrs[SP_IDX];
            rd_en    = 1'b1;
            upd_en   = 1'b1;
            upd_kind = PU_ADD;
            operand  = PTR_WIDTH'(1);
         end
         default:  illegal = 1'b1;
      endcase
      if ((op == PUSH || op == POP) && NUM_PTRS < 3) illegal = 1'b1;
      if ({1'b0, ptr_sel} >= NP_WIDE) illegal = 1'b1;
      if (illegal) begin
         rd_en  = 1'b0;
         wr_en  = 1'b0;
         upd_en = 1'b0;
      end
      addr = {acc_ptr, word_sel};
   end

   mem_pointer_file #(
      .PTR_WIDTH  (PTR_WIDTH),
      .NUM_PTRS   (NUM_PTRS),
      .PSEL_WIDTH (PSEL_W)
   ) u_ptr_file (
      .clock_i    (clock),
      .reset_i    (reset),
      .upd_en_i   (upd_en),
      .upd_idx_i  (upd_idx),
      .upd_kind_i (upd_kind),
      .operand_i  (operand),
      .ptrs_o     (ptrs),
      .wrap_o     (wrap_flags)
   );

   // Cell array has no reset and no same-cycle bypass.
   always_ff @(posedge clock) begin
      if (wr_en) mem_q[addr] <= in;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_data_q   <= '0;
         out_valid_q <= 1'b0;
         op_error_q  <= 1'b0;
      end else begin
         out_valid_q <= rd_en;
         op_error_q  <= illegal;
         if (rd_en) rd_data_q <= mem_q[addr];
      end
   end

   assign out_valid = out_valid_q;
   assign op_error  = op_error_q;
   assign out       = out_valid_q ? rd_data_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_pointer_memory.sv
// Directed bench for pointer_memory: read data checked by a cycle-stamped scoreboard,
// pointer/flag state checked directly after each step.
module tb_pointer_memory;
   import control::*;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] din = '0;
   logic [7:0] dout;
   logic       dvld;
   logic [0:0] ws = '0;
   logic [1:0] psel = '0;
   memory_op_e op = NOP;
   logic [3:0] wflags;
   logic       oerr;

   logic [7:0] din3 = '0;
   logic [7:0] dout3;
   logic       dvld3;
   logic [1:0] psel3 = '0;
   memory_op_e op3 = NOP;
   logic [2:0] wflags3;
   logic       oerr3;

   typedef struct {
      logic [7:0] dat;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   pointer_memory dut (
      .clock(clock), .reset(reset), .in(din), .out(dout), .out_valid(dvld),
      .word_sel(ws), .ptr_sel(psel), .op(op), .wrap_flags(wflags), .op_error(oerr)
   );

   pointer_memory #(.NUM_PTRS(3)) dut3 (
      .clock(clock), .reset(reset), .in(din3), .out(dout3), .out_valid(dvld3),
      .word_sel(ws), .ptr_sel(psel3), .op(op3), .wrap_flags(wflags3), .op_error(oerr3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_out_off(input string name);
      n_checks++;
      if (!(dout === 8'hzz || dout === 8'h00)) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h, required high-impedance", name, dout);
      end
   endtask

   task automatic issue(input memory_op_e o, input logic [1:0] s, input logic w,
                        input logic [7:0] d, input bit rd, input logic [7:0] ed);
      exp_t e;
      op   = o;
      psel = s;
      ws   = w;
      din  = d;
      if (rd) begin
         e.dat = ed;
         e.cyc = cyc + 1;
         exp_q.push_back(e);
      end
      @(posedge clock);
      #1;
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (dvld) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out_valid: actual 1 at cycle %0d, required 0", cyc);
         end else begin
            e = exp_q.pop_front();
            check("rd_data", dout, e.dat);
            check("rd_cycle", cyc, e.cyc);
         end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL missing_out_valid: actual 0 at cycle %0d, required 1 with 0x%0h", e.cyc, e.dat);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clock);
      #1;
      check("rst_out_valid", dvld, 0);
      check("rst_op_error", oerr, 0);
      check("rst_wrap_flags", wflags, 0);
      for (int i = 0; i < 4; i++) check($sformatf("rst_ptr%0d", i), dut.ptrs[i], 0);
      check_out_off("rst_out_z");
      reset = 1'b0;

      // ABSOLUTE/WRITE/READ round trip, write-then-read of the same address
      issue(ABSOLUTE, 2'd0, 1'b0, 8'h10, 0, 8'h00);
      check("ptr0_abs", dut.ptrs[0], 8'h10);
      issue(WRITE,    2'd0, 1'b1, 8'hA5, 0, 8'h00);
      issue(READ,     2'd0, 1'b1, 8'h00, 1, 8'hA5);
      issue(NOP,      2'd0, 1'b0, 8'h00, 0, 8'h00);
      check_out_off("out_z_after_read");
      issue(NOP,      2'd0, 1'b0, 8'h00, 0, 8'h00);

      // Relative arithmetic and wrap flag on PC
      issue(ABSOLUTE, 2'd1, 1'b0, 8'hFE, 0, 8'h00);
      issue(REL_ADD,  2'd1, 1'b0, 8'h03, 0, 8'h00);
      check("ptr1_add_wrap", dut.ptrs[1], 8'h01);
      check("wrap1_set", wflags[1], 1);
      issue(REL_SUB,  2'd1, 1'b0, 8'h02, 0, 8'h00);
      check("ptr1_sub_wrap", dut.ptrs[1], 8'hFF);
      check("wrap1_sticky", wflags[1], 1);
      issue(ABSOLUTE, 2'd1, 1'b0, 8'h00, 0, 8'h00);
      check("ptr1_abs0", dut.ptrs[1], 8'h00);
      check("wrap1_clear", wflags[1], 0);

      // Stack through SP from zero; ptr_sel is ignored by PUSH/POP
      issue(ABSOLUTE, 2'd2, 1'b0, 8'h00, 0, 8'h00);
      issue(PUSH,     2'd0, 1'b1, 8'h11, 0, 8'h00);
      check("sp_after_push", dut.ptrs[2], 8'hFF);
      issue(PUSH,     2'd0, 1'b1, 8'h22, 0, 8'h00);
      issue(POP,      2'd0, 1'b1, 8'h00, 1, 8'h22);
      issue(POP,      2'd0, 1'b1, 8'h00, 1, 8'h11);
      check("sp_after_pops", dut.ptrs[2], 8'h00);
      check("wrap_flags_stack", wflags, 4'b0100);
      check("ptr0_untouched", dut.ptrs[0], 8'h10);

      // Fill 0x20..0x23 via MAR, then streaming READ_INC through IDX
      issue(ABSOLUTE, 2'd0, 1'b0, 8'h20, 0, 8'h00);
      for (int i = 1; i <= 4; i++) begin
         issue(WRITE, 2'd0, 1'b0, 8'(i), 0, 8'h00);
         if (i < 4) issue(REL_ADD, 2'd0, 1'b0, 8'h01, 0, 8'h00);
      end
      issue(ABSOLUTE, 2'd3, 1'b0, 8'h20, 0, 8'h00);
      for (int i = 1; i <= 4; i++) issue(READ_INC, 2'd3, 1'b0, 8'h00, 1, 8'(i));
      issue(NOP, 2'd0, 1'b0, 8'h00, 0, 8'h00);
      check("ptr3_after_inc", dut.ptrs[3], 8'h24);
      check("ptr0_after_fill", dut.ptrs[0], 8'h23);

      // Illegal ops: undefined encoding here, out-of-range ptr_sel on the 3-pointer instance
      op3 = ABSOLUTE; psel3 = 2'd3; din3 = 8'h44;
      issue(memory_op_e'(4'hC), 2'd0, 1'b0, 8'h55, 0, 8'h00);
      check("op_error_undef", oerr, 1);
      check("op_error_psel", oerr3, 1);
      check("undef_ptr0", dut.ptrs[0], 8'h23);
      check("undef_ptr3", dut.ptrs[3], 8'h24);
      check("undef_wrap", wflags, 4'b0100);
      check("psel_ptrs3", dut3.ptrs, 24'h0);
      op3 = ABSOLUTE; psel3 = 2'd2; din3 = 8'h09;
      issue(NOP, 2'd0, 1'b0, 8'h00, 0, 8'h00);
      check("op_error_clear", oerr, 0);
      check("op_error3_legal", oerr3, 0);
      check("dut3_ptr2", dut3.ptrs[2], 8'h09);
      op3 = NOP;

      // Reset while a read is in flight drops the datum
      issue(ABSOLUTE, 2'd1, 1'b0, 8'h33, 0, 8'h00);
      op = READ; psel = 2'd0; ws = 1'b1;
      #3 reset = 1'b1;
      @(posedge clock);
      #1;
      op = NOP;
      check("midrd_out_valid", dvld, 0);
      check_out_off("midrd_out_z");
      check("midrd_ptrs", dut.ptrs, 32'h0);
      check("midrd_wrap", wflags, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (3) issue(NOP, 2'd0, 1'b0, 8'h00, 0, 8'h00);
      check("post_rst_out_valid", dvld, 0);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
